// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller for an RV32I integer subset.
// Drives an external ALU and register file; one instruction retires every 4 cycles with zero-wait fetch.
module multicycle_controller #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] data_A,
  output logic [31:0] data_B,
  output logic [3:0]  ALU_OP,
  input  logic [31:0] alu_out,
  input  logic        zero,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP} state_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] tgt_q, tgt_d, res_q, res_d;
  logic [3:0]  op_q, op_d;
  logic        z_q, z_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_b, dec_b;
  logic [3:0]  dec_op;
  logic        dec_legal, is_alu, take;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign is_alu = (opcode == OPC_R) || (opcode == OPC_I);
  assign take   = (opcode == OPC_B) && (funct3[0] ? !z_q : z_q);

  // Shift amounts are zero-extended into B because the ALU shifts by the whole operand.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 4'b0101;
    dec_b     = rs2_data;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_op    = funct7[5] ? 4'b0110 : 4'b0101;
          end
          3'b001: begin dec_legal = (funct7 == '0); dec_op = 4'b0011; dec_b = {27'd0, rs2_data[4:0]}; end
          3'b100: begin dec_legal = (funct7 == '0); dec_op = 4'b0010; end
          3'b101: begin dec_legal = (funct7 == '0); dec_op = 4'b0100; dec_b = {27'd0, rs2_data[4:0]}; end
          3'b110: begin dec_legal = (funct7 == '0); dec_op = 4'b0001; end
          3'b111: begin dec_legal = (funct7 == '0); dec_op = 4'b0000; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_I: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = 4'b0101; end
          3'b100: begin dec_legal = 1'b1; dec_op = 4'b0010; end
          3'b110: begin dec_legal = 1'b1; dec_op = 4'b0001; end
          3'b111: begin dec_legal = 1'b1; dec_op = 4'b0000; end
          3'b001: begin dec_legal = (funct7 == '0); dec_op = 4'b0011; dec_b = {27'd0, ir_q[24:20]}; end
          3'b101: begin dec_legal = (funct7 == '0); dec_op = 4'b0100; dec_b = {27'd0, ir_q[24:20]}; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_B: begin
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        dec_op    = 4'b0110;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tgt_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tgt_q   <= tgt_d;
      res_q   <= res_d;
      op_q    <= op_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    tgt_d   = tgt_q;
    res_d   = res_q;
    op_d    = op_q;
    z_d     = z_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          state_d = TRAP;
        end else begin
          a_d     = rs1_data;
          b_d     = dec_b;
          op_d    = dec_op;
          tgt_d   = pc_q + imm_b;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        res_d   = alu_out;
        z_d     = zero;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        pc_d    = take ? tgt_q : pc_q + 32'd4;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    rs1_addr  = '0;
    rs2_addr  = '0;
    data_A    = '0;
    data_B    = '0;
    ALU_OP    = '0;
    rd_we     = 1'b0;
    rd_addr   = '0;
    rd_wdata  = '0;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      DECODE: begin
        rs1_addr = ir_q[19:15];
        rs2_addr = ir_q[24:20];
      end
      EXECUTE: begin
        data_A = a_q;
        data_B = b_q;
        ALU_OP = op_q;
      end
      WRITEBACK: begin
        retire = 1'b1;
        if (is_alu && (ir_q[11:7] != '0)) begin
          rd_we    = 1'b1;
          rd_addr  = ir_q[11:7];
          rd_wdata = res_q;
        end
      end
      TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: behavioural ALU, register file and instruction
// memory around the DUT, with an instruction-level reference model feeding a scoreboard queue.
module tb_multicycle_controller;

  localparam logic [31:0] PCR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, data_A, data_B, alu_out, rd_wdata;
  logic [3:0]  ALU_OP;
  logic        zero, rd_we, retire, illegal;

  multicycle_controller #(.PC_RESET(PCR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .data_A(data_A), .data_B(data_B), .ALU_OP(ALU_OP), .alu_out(alu_out), .zero(zero),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Environment: register file and ALU
  logic [31:0] rf [32] = '{default: '0};
  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];
  always @(posedge clk) if (rd_we && rd_addr != 5'd0) rf[rd_addr] <= rd_wdata;

  always_comb begin
    case (ALU_OP)
      4'b0000: alu_out = data_A & data_B;
      4'b0001: alu_out = data_A | data_B;
      4'b0010: alu_out = data_A ^ data_B;
      4'b0011: alu_out = data_A << data_B;
      4'b0100: alu_out = data_A >> data_B;
      4'b0101: alu_out = data_A + data_B;
      4'b0110: alu_out = data_A - data_B;
      default: alu_out = '0;
    endcase
  end
  assign zero = (alu_out == 32'd0);

  logic [150:0] allout;
  assign allout = {imem_req, imem_addr, rs1_addr, rs2_addr, data_A, data_B, ALU_OP,
                   rd_we, rd_addr, rd_wdata, retire, illegal};

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        illegal;
    logic        we;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] a, b, wdata, next_pc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] g_rf [32] = '{default: '0};
  logic [31:0] exp_pc = PCR;
  int unsigned prev_cyc = 0;
  bit          prev_valid = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] av, bv, imm, bimm, res;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        alu, taken;
    e = '0; e.illegal = 1'b1; e.op = 4'b0101;
    f7 = ins[31:25]; f3 = ins[14:12];
    av = g_rf[ins[19:15]]; bv = g_rf[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    alu = 1'b0; taken = 1'b0; res = '0;
    case (ins[6:0])
      7'b0110011: begin
        alu = 1'b1;
        if (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0)) begin
          case (f3)
            3'd0: begin e.illegal = 0; e.op = f7[5] ? 4'd6 : 4'd5; res = f7[5] ? av - bv : av + bv; end
            3'd1: begin e.illegal = 0; e.op = 4'd3; bv = {27'd0, bv[4:0]}; res = av << bv[4:0]; end
            3'd4: begin e.illegal = 0; e.op = 4'd2; res = av ^ bv; end
            3'd5: begin e.illegal = 0; e.op = 4'd4; bv = {27'd0, bv[4:0]}; res = av >> bv[4:0]; end
            3'd6: begin e.illegal = 0; e.op = 4'd1; res = av | bv; end
            3'd7: begin e.illegal = 0; e.op = 4'd0; res = av & bv; end
            default: ;
          endcase
        end
      end
      7'b0010011: begin
        alu = 1'b1; bv = imm;
        case (f3)
          3'd0: begin e.illegal = 0; e.op = 4'd5; res = av + imm; end
          3'd4: begin e.illegal = 0; e.op = 4'd2; res = av ^ imm; end
          3'd6: begin e.illegal = 0; e.op = 4'd1; res = av | imm; end
          3'd7: begin e.illegal = 0; e.op = 4'd0; res = av & imm; end
          3'd1: if (f7 == 7'h00) begin
            e.illegal = 0; e.op = 4'd3; bv = {27'd0, ins[24:20]}; res = av << ins[24:20];
          end
          3'd5: if (f7 == 7'h00) begin
            e.illegal = 0; e.op = 4'd4; bv = {27'd0, ins[24:20]}; res = av >> ins[24:20];
          end
          default: ;
        endcase
      end
      7'b1100011: begin
        if (f3 == 3'd0 || f3 == 3'd1) begin
          e.illegal = 0; e.op = 4'd6;
          taken = f3[0] ? (av != bv) : (av == bv);
        end
      end
      default: ;
    endcase
    e.a = av; e.b = bv; e.rd = ins[11:7]; e.wdata = res;
    e.we = alu && !e.illegal && (ins[11:7] != 5'd0);
    e.next_pc = taken ? pc + bimm : pc + 32'd4;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = PCR; prev_valid = 0; sb.delete();
  endtask

  task automatic wait_req(input string tag, output bit ok);
    int unsigned guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    ok = (imem_req === 1'b1);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_req_timeout: imem_req=%b expected 1", tag, imem_req); end
  endtask

  task automatic run_instr(input logic [31:0] ins, input int unsigned delay);
    exp_t e, p;
    bit ok;
    wait_req("run", ok);
    if (!ok) return;
    n_tests++;
    if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_pc); end
    sb.push_back(model(ins, exp_pc));
    ok = 1;
    repeat (delay) begin
      @(posedge clk); #1;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) ok = 0;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL addr_stable: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, exp_pc); end
    imem_ack = 1'b1; imem_rdata = ins;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = '0;
    n_tests++;
    if (rs1_addr !== ins[19:15] || imem_req !== 1'b0 || retire !== 1'b0) begin
      n_fail++; $display("FAIL decode: got rs1=%0d req=%b retire=%b expected %0d/0/0", rs1_addr, imem_req, retire, ins[19:15]);
    end
    @(posedge clk); #1;
    p = sb.pop_front();
    if (p.illegal) begin
      n_tests++;
      if (illegal !== 1'b1) begin n_fail++; $display("FAIL trap_flag: got %b expected 1", illegal); end
      ok = 1;
      repeat (8) begin
        @(posedge clk); #1;
        if (imem_req !== 1'b0 || rd_we !== 1'b0 || retire !== 1'b0 || illegal !== 1'b1) ok = 0;
      end
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL trap_terminal: got req=%b we=%b retire=%b illegal=%b expected 0/0/0/1", imem_req, rd_we, retire, illegal); end
      return;
    end
    n_tests++;
    if (ALU_OP !== p.op || data_A !== p.a || data_B !== p.b || illegal !== 1'b0) begin
      n_fail++; $display("FAIL execute: got op=%h A=%h B=%h ill=%b expected %h/%h/%h/0", ALU_OP, data_A, data_B, illegal, p.op, p.a, p.b);
    end
    @(posedge clk); #1;
    n_tests++;
    if (retire !== 1'b1 || rd_we !== p.we) begin
      n_fail++; $display("FAIL wb_strobes: got retire=%b we=%b expected 1/%b", retire, rd_we, p.we);
    end
    if (p.we) begin
      n_tests++;
      if (rd_addr !== p.rd || rd_wdata !== p.wdata) begin
        n_fail++; $display("FAIL wb_data: got x%0d=%h expected x%0d=%h", rd_addr, rd_wdata, p.rd, p.wdata);
      end
      g_rf[p.rd] = p.wdata;
    end
    if (prev_valid) begin
      n_tests++;
      if (cyc - prev_cyc != 4 + delay) begin
        n_fail++; $display("FAIL retire_spacing: got %0d expected %0d", cyc - prev_cyc, 4 + delay);
      end
    end
    prev_cyc = cyc; prev_valid = 1;
    exp_pc = p.next_pc;
    @(posedge clk); #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc || retire !== 1'b0) begin
      n_fail++; $display("FAIL next_fetch: got req=%b addr=%h retire=%b expected 1/%h/0", imem_req, imem_addr, retire, exp_pc);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (allout !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", allout); end
    rst_n = 1'b1; #1;
    n_tests++;
    if (allout !== '0) begin n_fail++; $display("FAIL boot_outputs: got %h expected 0", allout); end
    @(posedge clk); #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== PCR) begin
      n_fail++; $display("FAIL first_fetch: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, PCR);
    end
  endtask

  task automatic test_alu();
    run_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd2), 0);
    run_instr(32'h0050_0093, 0);
    run_instr(32'h0020_81B3, 0);
    run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 0);
    run_instr(enc_i(12'hFFF, 5'd4, 3'd4, 5'd5), 0);
    run_instr(enc_i({7'h00, 5'd4}, 5'd2, 3'd1, 5'd6), 0);
    run_instr(enc_i({7'h00, 5'd28}, 5'd4, 3'd5, 5'd7), 0);
    run_instr(enc_r(7'h00, 5'd3, 5'd2, 3'd1, 5'd8), 0);
    run_instr(enc_r(7'h00, 5'd1, 5'd4, 3'd5, 5'd9), 0);
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd10), 0);
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd11), 0);
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd12), 0);
    run_instr(enc_i(12'h7FF, 5'd0, 3'd6, 5'd13), 0);
    run_instr(enc_i(12'h0F0, 5'd4, 3'd7, 5'd14), 0);
    run_instr(enc_r(7'h00, 5'd4, 5'd2, 3'd1, 5'd15), 0);
  endtask

  task automatic test_branch();
    logic [31:0] off;
    off = 32'h10 - exp_pc;
    run_instr(enc_b(off[12:0], 5'd0, 5'd0, 3'd0), 0);
    run_instr(32'h0010_8463, 0);
    run_instr(32'h0010_9463, 0);
    run_instr(enc_b(-13'sd12, 5'd2, 5'd1, 3'd1), 0);
    run_instr(enc_b(13'd64, 5'd2, 5'd1, 3'd0), 0);
  endtask

  task automatic test_x0_write();
    run_instr(32'h0070_0013, 0);
  endtask

  task automatic test_wait();
    run_instr(enc_i(12'd33, 5'd0, 3'd0, 5'd16), 3);
    run_instr(enc_i(12'd1, 5'd16, 3'd0, 5'd16), 1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_req("mid", ok);
    if (!ok) return;
    imem_ack = 1'b1; imem_rdata = enc_i(12'd99, 5'd0, 3'd0, 5'd17);
    @(posedge clk); #1; imem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_tests++;
    if (allout !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", allout); end
    ok = 1;
    repeat (3) begin @(posedge clk); #1; if (rd_we !== 1'b0 || retire !== 1'b0) ok = 0; end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL midreset_nowrite: got we=%b retire=%b expected 0/0", rd_we, retire); end
    @(negedge clk); rst_n = 1'b1;
    exp_pc = PCR; prev_valid = 0; sb.delete();
    @(posedge clk); #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== PCR) begin
      n_fail++; $display("FAIL midreset_restart: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, PCR);
    end
    run_instr(enc_r(7'h00, 5'd2, 5'd17, 3'd0, 5'd18), 0);
  endtask

  task automatic test_illegal();
    run_instr(32'hFFFF_FFFF, 0);
    do_reset();
    run_instr(32'h4020_D1B3, 0);
    do_reset();
    run_instr(enc_i({7'h20, 5'd3}, 5'd1, 3'd5, 5'd1), 0);
    do_reset();
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd1), 0);
    do_reset();
    run_instr(enc_i(12'd3, 5'd0, 3'd0, 5'd19), 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_x0_write();
    test_wait();
    test_reset_mid();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle fetch/decode/execute/writeback controller for the RV32I integer subset. It drives the `Instruction_Excute` ALU's `data_A`, `data_B` and `ALU_OP`, and consumes `ALU_OUT` and `zero`. It also sequences instruction-memory fetches, register-file reads and writes, and the program counter. One instruction retires every 4 cycles with zero-wait memory.

## Interface
Parameters:
- PC_RESET, default 32'h0000_0000: PC value loaded on reset.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= PC).
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  instruction word.
- rs1_addr, rs2_addr  out  5 each  register-file read addresses (combinational read).
- rs1_data, rs2_data  in  32 each  register-file read data.
- data_A, data_B  out  32 each  ALU operands.
- ALU_OP  out  4  ALU operation select: 0000 and, 0001 or, 0010 xor, 0011 sll, 0100 srl, 0101 add, 0110 sub.
- alu_out  in  32  ALU result.
- zero  in  1  ALU zero flag.
- rd_we  out  1  register write strobe.
- rd_addr  out  5  write address.
- rd_wdata  out  32  write data.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  sticky illegal-instruction flag.

## Operation
- States: BOOT, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP. Reset enters BOOT.
- BOOT:
  - All strobes low.
  - Go to FETCH next cycle.
- FETCH:
  - imem_req=1; imem_addr=PC, held stable.
  - On imem_ack=1, latch imem_rdata into IR and go to DECODE. Otherwise stay.
- DECODE:
  - rs1_addr=IR[19:15], rs2_addr=IR[24:20].
  - Latch rs1_data into A.
  - Latch B: rs2_data (R-type, branch), or sign-extended I-imm (I-type). For slli/srli, B = zero-extended IR[24:20].
  - Latch ALU_OP and branch target = PC + sign-extended B-imm.
  - Unsupported encoding: go to TRAP. Otherwise go to EXECUTE.
- Supported encodings:
  - R-type (opcode 0110011): add/sub (funct3 000, funct7 0000000/0100000), sll 001, xor 100, srl 101, or 110, and 111. funct7 must be 0000000 except for sub.
  - I-type (opcode 0010011): addi, xori, ori, andi, slli, srli. Shift-immediates require IR[31:25]=0.
  - Branch (opcode 1100011): beq (funct3 000), bne (001). Both use ALU_OP=0110 (sub).
  - Everything else is illegal, including sra/srai and loads/stores.
- EXECUTE:
  - data_A/data_B/ALU_OP come from latched registers; they are valid only in this state.
  - Latch alu_out into result and zero into Z.
  - Go to WRITEBACK.
- WRITEBACK:
  - ALU types: rd_we=1, rd_addr=IR[11:7], rd_wdata=result. If rd=0, rd_we stays 0.
  - Branches never write.
  - PC update: beq with Z=1, or bne with Z=0, loads the target; otherwise PC+4 (mod 2^32).
  - retire=1; go to FETCH.
- TRAP:
  - illegal=1. Terminal until reset: no requests, no writes, PC frozen at the faulting address.
- Shift amounts always fit in 5 bits. The R-type shift uses rs2_data[4:0] zero-extended in B, because the ALU shifts by all of B.

## Timing
- Reset values, asserted immediately on rst_n low and regardless of state:
  - imem_req=0, rd_we=0, retire=0, illegal=0.
  - data_A=0, data_B=0, ALU_OP=0000.
  - rd_addr=0, rd_wdata=0, rs1_addr=0, rs2_addr=0.
  - PC=PC_RESET.
- Reset mid-instruction aborts it with no write and no retire.
- After rst_n rises: BOOT for 1 cycle, then imem_req rises with imem_addr=PC_RESET.
- imem_ack is sampled only while imem_req=1.
  - An ack in the first FETCH cycle gives 4 cycles/instruction.
  - Each wait cycle adds 1.
- rd_we and retire are single-cycle, coincident, and registered (high during the WRITEBACK cycle).
- New imem_addr is visible in the first cycle of the following FETCH.
- No pipelining: a register written in WRITEBACK is read by the next instruction's DECODE ≥2 cycles later, so there is no hazard.

## Test plan
- Reset with PC_RESET=32'h100 -> all outputs 0; first imem_req at cycle 2 after release with imem_addr=32'h100.
- Fetch 0x00500093 (addi x1,x0,5), then 0x002081B3 (add x3,x1,x2) with x2=7 -> first: rd_we with rd_addr=1, rd_wdata=5, ALU_OP=0101 in EXECUTE. Second: rd_addr=3, rd_wdata=12, retire every 4th cycle.
- 0x00108463 (beq x1,x1,+8) at PC=0x10 -> ALU_OP=0110, no rd_we, next imem_addr=0x18. Same word with funct3=001 (bne, 0x00109463) -> next imem_addr=0x14.
- 0x00700013 (addi x0,x0,7) -> retire=1, rd_we=0.
- 0xFFFFFFFF, or sra (0x4020D1B3) -> illegal=1 after DECODE; no further imem_req, rd_we or retire until reset.
- imem_ack delayed 3 cycles -> imem_addr stable throughout; instruction retires at cycle 7. Asserting rst_n=0 during EXECUTE -> no rd_we, restart from PC_RESET.
